// File: rtl/fold_valid_pipe.sv
// ---------------------------------------------------------------------------
// fold_valid_pipe
//
// Registered fold-window valid decoder between the instruction buffer and
// the fold/decode logic. Starting at byte 0, it follows the per-byte
// instruction lengths to find the start offset of each prospective fold
// slot. Each slot is then qualified against the per-byte fetch valids. The
// slot valids, offsets and valid-slot count are registered into the decode
// stage with hold and flush. A saturating counter tracks decode starvation:
// consecutive loaded cycles in which slot 0 is not valid.
//
// Ports:
//   clk          in   clock
//   reset_l      in   asynchronous active-low reset
//   fetch_valid  in   [IBUF_BYTES]       per-byte fetch valid
//   fetch_len    in   [IBUF_BYTES*LENW]  instruction length starting at byte i
//   iu_hold      in   stall: all registers keep their value
//   iu_flush     in   squash: slot outputs and starve counter cleared (beats hold)
//   dec_valid    out  [NSLOTS]           registered slot valids (contiguous prefix)
//   dec_offset   out  [NSLOTS*OFFW]      registered slot start offsets, 0 when invalid
//   dec_count    out  [CNTW]             registered number of valid slots
//   starve_cnt   out  [STARVE_W]         saturating starvation counter
//   starve_flag  out  starve_cnt is all-ones
// ---------------------------------------------------------------------------
module fold_valid_pipe #(
    parameter int IBUF_BYTES   = 7,
    parameter int NSLOTS       = 4,
    parameter int LENW         = 4,
    parameter int MAXLEN       = 3,
    parameter int FIRST_MAXLEN = 5,
    parameter int OFFW         = 3,
    parameter int STARVE_W     = 8,
    localparam int CNTW        = $clog2(NSLOTS + 1)
) (
    input  logic                       clk,
    input  logic                       reset_l,
    input  logic [IBUF_BYTES-1:0]      fetch_valid,
    input  logic [IBUF_BYTES*LENW-1:0] fetch_len,
    input  logic                       iu_hold,
    input  logic                       iu_flush,
    output logic [NSLOTS-1:0]          dec_valid,
    output logic [NSLOTS*OFFW-1:0]     dec_offset,
    output logic [CNTW-1:0]            dec_count,
    output logic [STARVE_W-1:0]        starve_cnt,
    output logic                       starve_flag
);

    // Offset sums are wide enough that walking NSLOTS maximal lengths past
    // the end of the buffer never wraps back into range.
    localparam int SUMW = $clog2(IBUF_BYTES + NSLOTS * ((1 << LENW) - 1) + 1);

    logic [NSLOTS-1:0]      valid_d;
    logic [NSLOTS*OFFW-1:0] offset_d;
    logic [CNTW-1:0]        count_d;
    logic [STARVE_W-1:0]    starve_d;
    logic                   flag_d;

    logic [NSLOTS-1:0]      valid_q;
    logic [NSLOTS*OFFW-1:0] offset_q;
    logic [CNTW-1:0]        count_q;
    logic [STARVE_W-1:0]    starve_q;
    logic                   flag_q;

    // Slot walk: chain offsets through the length fields and qualify each slot.
    always_comb begin
        logic [SUMW-1:0] off_v;
        logic [SUMW-1:0] len_v;
        logic [SUMW-1:0] lim_v;
        logic            prev_v;
        logic            bytes_ok_v;
        logic            in_rng_v;
        logic            ok_v;

        valid_d  = '0;
        offset_d = '0;
        count_d  = '0;
        off_v    = '0;
        len_v    = '0;
        lim_v    = '0;
        prev_v   = 1'b1;

        for (int k = 0; k < NSLOTS; k++) begin
            // The length is only picked up from an in-range byte; an
            // out-of-range offset yields length 0, which fails the slot.
            len_v = '0;
            for (int j = 0; j < IBUF_BYTES; j++) begin
                len_v = (off_v == SUMW'(j)) ? SUMW'(fetch_len[j*LENW +: LENW]) : len_v;
            end

            // Every byte the instruction covers must have been fetched.
            bytes_ok_v = 1'b1;
            for (int j = 0; j < IBUF_BYTES; j++) begin
                in_rng_v   = (SUMW'(j) >= off_v) && (SUMW'(j) < (off_v + len_v));
                bytes_ok_v = bytes_ok_v & (~in_rng_v | fetch_valid[j]);
            end

            lim_v = (k == 0) ? SUMW'(FIRST_MAXLEN) : SUMW'(MAXLEN);

            ok_v = prev_v
                && (off_v < SUMW'(IBUF_BYTES))
                && (len_v >= SUMW'(1))
                && (len_v <= lim_v)
                && ((off_v + len_v) <= SUMW'(IBUF_BYTES))
                && bytes_ok_v;

            valid_d[k]                 = ok_v;
            offset_d[k*OFFW +: OFFW]   = ok_v ? off_v[OFFW-1:0] : {OFFW{1'b0}};
            count_d                    = ok_v ? (count_d + CNTW'(1)) : count_d;

            prev_v = ok_v;
            off_v  = off_v + len_v;
        end
    end

    // Starvation counter next value: clear on a valid first slot, else saturate upward.
    always_comb begin
        starve_d = starve_q;
        if (valid_d[0]) begin
            starve_d = '0;
        end else if (starve_q != {STARVE_W{1'b1}}) begin
            starve_d = starve_q + STARVE_W'(1);
        end else begin
            starve_d = starve_q;
        end
        flag_d = (starve_d == {STARVE_W{1'b1}});
    end

    // Decode-stage registers: flush beats hold, hold beats load.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            valid_q  <= '0;
            offset_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            flag_q   <= 1'b0;
        end else if (iu_flush) begin
            valid_q  <= '0;
            offset_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            flag_q   <= 1'b0;
        end else if (iu_hold) begin
            valid_q  <= valid_q;
            offset_q <= offset_q;
            count_q  <= count_q;
            starve_q <= starve_q;
            flag_q   <= flag_q;
        end else begin
            valid_q  <= valid_d;
            offset_q <= offset_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            flag_q   <= flag_d;
        end
    end

    assign dec_valid   = valid_q;
    assign dec_offset  = offset_q;
    assign dec_count   = count_q;
    assign starve_cnt  = starve_q;
    assign starve_flag = flag_q;

endmodule

// File: tb/tb_fold_valid_pipe.sv
// ---------------------------------------------------------------------------
// tb_fold_valid_pipe
//
// Self-checking bench for fold_valid_pipe with default parameters: a table
// of directed vectors, hand-written reset and starvation sequences, and a
// randomized run compared against a behavioural model of the slot rules.
// ---------------------------------------------------------------------------
module tb_fold_valid_pipe;

    logic        clk;
    logic        reset_l;
    logic [6:0]  fetch_valid;
    logic [27:0] fetch_len;
    logic        iu_hold;
    logic        iu_flush;
    logic [3:0]  dec_valid;
    logic [11:0] dec_offset;
    logic [2:0]  dec_count;
    logic [7:0]  starve_cnt;
    logic        starve_flag;

    fold_valid_pipe dut (
        .clk         (clk),
        .reset_l     (reset_l),
        .fetch_valid (fetch_valid),
        .fetch_len   (fetch_len),
        .iu_hold     (iu_hold),
        .iu_flush    (iu_flush),
        .dec_valid   (dec_valid),
        .dec_offset  (dec_offset),
        .dec_count   (dec_count),
        .starve_cnt  (starve_cnt),
        .starve_flag (starve_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected register state kept by the model.
    logic [3:0]  m_valid;
    logic [11:0] m_off;
    logic [2:0]  m_cnt;
    int          m_starve;

    typedef struct {
        logic [6:0]  v;
        logic [27:0] l;
        logic        h;
        logic        f;
        logic [3:0]  ev;
        logic [11:0] eo;
        logic [2:0]  ec;
    } vec_t;

    vec_t tbl [12];

    function automatic logic [27:0] mk_len(input int b0, input int b1, input int b2,
                                           input int b3, input int b4, input int b5,
                                           input int b6);
        int          b [7];
        logic [27:0] r;
        b = '{b0, b1, b2, b3, b4, b5, b6};
        r = '0;
        for (int i = 0; i < 7; i++) r[i*4 +: 4] = 4'(b[i]);
        return r;
    endfunction

    // Walk instructions from byte 0 with plain integer positions.
    task automatic model_slots(input logic [6:0] v, input logic [27:0] l,
                               output logic [3:0] ev, output logic [11:0] eo,
                               output logic [2:0] ec);
        int  pos;
        int  len;
        int  lim;
        bit  good;
        ev  = '0;
        eo  = '0;
        ec  = '0;
        pos = 0;
        for (int k = 0; k < 4; k++) begin
            if (pos >= 7) break;
            len  = int'(l[pos*4 +: 4]);
            lim  = (k == 0) ? 5 : 3;
            if (len < 1 || len > lim || pos + len > 7) break;
            good = 1'b1;
            for (int b = pos; b < pos + len; b++) if (!v[b]) good = 1'b0;
            if (!good) break;
            ev[k]        = 1'b1;
            eo[k*3 +: 3] = 3'(pos);
            ec           = ec + 3'd1;
            pos          = pos + len;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"},  32'(dec_valid),   32'(m_valid));
        check({tag, ".offset"}, 32'(dec_offset),  32'(m_off));
        check({tag, ".count"},  32'(dec_count),   32'(m_cnt));
        check({tag, ".starve"}, 32'(starve_cnt),  32'(m_starve));
        check({tag, ".flag"},   32'(starve_flag), 32'(m_starve == 255));
    endtask

    // Apply one cycle of inputs, advance the model across the edge, compare.
    task automatic step(input logic [6:0] v, input logic [27:0] l,
                        input logic h, input logic f, input string tag);
        logic [3:0]  ev;
        logic [11:0] eo;
        logic [2:0]  ec;
        fetch_valid = v;
        fetch_len   = l;
        iu_hold     = h;
        iu_flush    = f;
        @(posedge clk);
        #1;
        if (f) begin
            m_valid = '0; m_off = '0; m_cnt = '0; m_starve = 0;
        end else if (!h) begin
            model_slots(v, l, ev, eo, ec);
            m_valid  = ev;
            m_off    = eo;
            m_cnt    = ec;
            m_starve = ev[0] ? 0 : ((m_starve < 255) ? m_starve + 1 : 255);
        end
        check_model(tag);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"},  32'(dec_valid),   32'd0);
        check({tag, ".offset"}, 32'(dec_offset),  32'd0);
        check({tag, ".count"},  32'(dec_count),   32'd0);
        check({tag, ".starve"}, 32'(starve_cnt),  32'd0);
        check({tag, ".flag"},   32'(starve_flag), 32'd0);
    endtask

    logic [27:0] l_t1, l_t2, l_t3a, l_t3b, l_t4, l_max;

    initial begin
        l_t1  = mk_len(1, 2, 0, 1, 3, 0, 0);
        l_t2  = mk_len(2, 0, 3, 0, 0, 1, 0);
        l_t3a = mk_len(6, 1, 1, 1, 1, 1, 1);
        l_t3b = mk_len(1, 4, 1, 1, 1, 1, 1);
        l_t4  = mk_len(3, 0, 0, 3, 0, 0, 2);
        l_max = mk_len(5, 0, 0, 0, 0, 2, 0);

        tbl[0]  = '{7'h7F, l_t1,  1'b0, 1'b0, 4'hF, {3'd4, 3'd3, 3'd1, 3'd0}, 3'd4};
        tbl[1]  = '{7'h1F, l_t2,  1'b0, 1'b0, 4'h3, {3'd0, 3'd0, 3'd2, 3'd0}, 3'd2};
        tbl[2]  = '{7'h7F, l_t3a, 1'b0, 1'b0, 4'h0, 12'h000,                  3'd0};
        tbl[3]  = '{7'h7F, l_t3b, 1'b0, 1'b0, 4'h1, 12'h000,                  3'd1};
        tbl[4]  = '{7'h7F, l_t4,  1'b0, 1'b0, 4'h3, {3'd0, 3'd0, 3'd3, 3'd0}, 3'd2};
        tbl[5]  = '{7'h7F, l_max, 1'b0, 1'b0, 4'h3, {3'd0, 3'd0, 3'd5, 3'd0}, 3'd2};
        tbl[6]  = '{7'h7F, l_t1,  1'b0, 1'b0, 4'hF, {3'd4, 3'd3, 3'd1, 3'd0}, 3'd4};
        tbl[7]  = '{7'h1F, l_t2,  1'b1, 1'b0, 4'hF, {3'd4, 3'd3, 3'd1, 3'd0}, 3'd4};
        tbl[8]  = '{7'h00, l_t3a, 1'b1, 1'b0, 4'hF, {3'd4, 3'd3, 3'd1, 3'd0}, 3'd4};
        tbl[9]  = '{7'h7F, l_t4,  1'b1, 1'b0, 4'hF, {3'd4, 3'd3, 3'd1, 3'd0}, 3'd4};
        tbl[10] = '{7'h7F, l_t1,  1'b1, 1'b1, 4'h0, 12'h000,                  3'd0};
        tbl[11] = '{7'h01, l_t3b, 1'b0, 1'b0, 4'h1, 12'h000,                  3'd1};

        m_valid = '0; m_off = '0; m_cnt = '0; m_starve = 0;

        // Reset held with random inputs, including hold/flush.
        reset_l = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fetch_valid = 7'($urandom);
            fetch_len   = 28'($urandom);
            iu_hold     = 1'($urandom);
            iu_flush    = 1'($urandom);
            @(posedge clk);
            #1;
        end
        check_zero("reset");
        @(negedge clk);
        reset_l = 1'b1;

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].v, tbl[i].l, tbl[i].h, tbl[i].f, $sformatf("vec%0d", i));
            check($sformatf("tbl%0d.valid", i),  32'(dec_valid),  32'(tbl[i].ev));
            check($sformatf("tbl%0d.offset", i), 32'(dec_offset), 32'(tbl[i].eo));
            check($sformatf("tbl%0d.count", i),  32'(dec_count),  32'(tbl[i].ec));
        end
        // Illegal first length bumps the starve counter by one from zero.
        step(7'h7F, l_t3a, 1'b0, 1'b0, "illegal0");
        check("illegal0.starve_exact", 32'(starve_cnt), 32'd1);

        // Starvation: counter saturates at 255, holding at the top.
        for (int i = 0; i < 260; i++) begin
            step(7'h00, 28'($urandom), 1'b0, 1'b0, "starve");
        end
        check("starve.sat_cnt",  32'(starve_cnt),  32'd255);
        check("starve.sat_flag", 32'(starve_flag), 32'd1);
        step(7'h7F, l_t1, 1'b0, 1'b0, "unstarve");
        check("unstarve.cnt",  32'(starve_cnt),  32'd0);
        check("unstarve.flag", 32'(starve_flag), 32'd0);

        // Asynchronous reset asserted mid-hold clears outputs without an edge.
        step(7'h00, l_t1, 1'b0, 1'b0, "pre_rst");
        fetch_valid = 7'h7F;
        iu_hold     = 1'b1;
        #2;
        reset_l = 1'b0;
        #1;
        check_zero("async_rst");
        m_valid = '0; m_off = '0; m_cnt = '0; m_starve = 0;
        @(negedge clk);
        reset_l = 1'b1;
        step(7'h7F, l_t1, 1'b0, 1'b0, "post_rst");
        check("post_rst.valid", 32'(dec_valid), 32'hF);

        // Randomized run against the model.
        for (int i = 0; i < 400; i++) begin
            logic [6:0]  rv;
            logic [27:0] rl;
            rv = ($urandom_range(0, 3) != 0) ? 7'h7F : 7'($urandom);
            rl = '0;
            for (int b = 0; b < 7; b++) rl[b*4 +: 4] = 4'($urandom_range(0, 6));
            step(rv, rl, 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 19) == 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
